teclado_digitos: RTL

Keypad front end for the lock: scans a 4x4 active-low matrix keypad, debounces presses, and assembles digit keys into the 20-digit `senhaPac_t` packet consumed by the setup and unlock logic. It drives `digitos_value`/`digitos_valid`, the producer side of the interface `setup` reads. Confirm, exit and inactivity timeout are encoded in the packet exactly as consumers decode them.

---
 rtl/teclado_digitos_if.sv | 10 +
 rtl/teclado_digitos.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/teclado_digitos_if.sv
// rtl/teclado_digitos_if.sv - keypad packet stream between teclado_digitos and its consumers
// digitos_value is senhaPac_t: 20 nibbles, digits[0] (bits 3:0) is the newest.
interface teclado_digitos_if;
  logic [19:0][3:0] digitos_value;
  logic             digitos_valid;
  logic             key_pulse;

  modport master (output digitos_value, output digitos_valid, output key_pulse);
  modport slave  (input  digitos_value, input  digitos_valid, input  key_pulse);
endinterface

// File: rtl/teclado_digitos.sv
// rtl/teclado_digitos.sv - 4x4 keypad scanner, debouncer and senhaPac_t packet assembler
// Confirm/exit/timeout are encoded into the packet the way setup/unlock decode them.
module teclado_digitos #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row_i,
  output logic [3:0]       col_o,
  teclado_digitos_if.master dig
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  // Internal key codes: 0-9 digits, A-D letters, E = '*', F = '#'
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [19:0][3:0] PKT_EMPTY   = {20{4'hF}};
  localparam logic [19:0][3:0] PKT_TIMEOUT = {20{4'hE}};
  localparam logic [19:0][3:0] PKT_EXIT    = {{19{4'hF}}, 4'hB};

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD} state_t;

  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = KEY_STAR; 4'hD: k = 4'h0; 4'hE: k = KEY_HASH; 4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]       row_s1_q, row_s2_q;
  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             key_pulse_q, key_pulse_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [19:0][3:0] buf_q, buf_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             com_q, com_d;
  logic             valid_q, valid_d;
  logic [TMO_W-1:0] idle_q, idle_d;

  logic       any_low;
  logic [1:0] row_sel;
  logic       accept;
  logic [3:0] key_now;

  always_comb begin
    row_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) row_sel = 2'(i);
    end
  end

  assign any_low = ~&row_s2_q;
  assign key_now = key_at(row_q, col_q);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    accept     = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (any_low) begin
          row_d      = row_sel;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          state_d    = DEB_PRESS;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end
      DEB_PRESS: begin
        if (!any_low || row_sel != row_q) begin
          deb_cnt_d = '0;
          state_d   = SCAN;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = '0;
          accept    = 1'b1;
          state_d   = HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      HELD: begin
        // Any row low restarts the release window, so a key fires once per press
        if (any_low) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = '0;
          state_d   = SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    key_pulse_d = accept && (key_now <= 4'h9 || key_now == KEY_STAR || key_now == KEY_HASH);
    key_code_d  = accept ? key_now : key_code_q;
  end

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    com_d   = com_q;
    valid_d = 1'b0;
    idle_d  = idle_q;
    if (key_pulse_q) begin
      idle_d = '0;
      if (key_code_q <= 4'h9) begin
        if (com_q) begin
          buf_d = {PKT_EMPTY[18:0], key_code_q};
          cnt_d = 5'd1;
          com_d = 1'b0;
        end else if (cnt_q < 5'd20) begin
          buf_d = {buf_q[18:0], key_code_q};
          cnt_d = cnt_q + 5'd1;
        end
      end else if (key_code_q == KEY_STAR) begin
        valid_d = 1'b1;
        com_d   = 1'b1;
      end else begin
        buf_d   = PKT_EXIT;
        valid_d = 1'b1;
        com_d   = 1'b1;
      end
    end else if (cnt_q != 5'd0 && !com_q) begin
      if (idle_q == TMO_LAST) begin
        buf_d   = PKT_TIMEOUT;
        valid_d = 1'b1;
        com_d   = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      key_pulse_q <= 1'b0;
      key_code_q  <= 4'h0;
      buf_q       <= PKT_EMPTY;
      cnt_q       <= 5'd0;
      com_q       <= 1'b0;
      valid_q     <= 1'b0;
      idle_q      <= '0;
    end else begin
      row_s1_q    <= row_i;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      key_pulse_q <= key_pulse_d;
      key_code_q  <= key_code_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      com_q       <= com_d;
      valid_q     <= valid_d;
      idle_q      <= idle_d;
    end
  end

  assign col_o             = ~(4'b0001 << col_q);
  assign dig.digitos_value = buf_q;
  assign dig.digitos_valid = valid_q;
  assign dig.key_pulse     = key_pulse_q;

endmodule
